// File: rtl/tdm_pkg.sv
// Shared constants and state encoding for the 8-slot TDM receive path.
package tdm_pkg;

   localparam int NUM_SLOTS  = 8;
   localparam int SLOT_W     = 3;
   localparam int DATA_W_DEF = 1;

   typedef enum logic [0:0] {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } tdm_state_e;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot pointer for the TDM demux, plus the consecutive-missing-sync counter.
module tdm_slot_ctr
   import tdm_pkg::*;
#(
   parameter int MISS_LIMIT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc,
   input  logic              load_one,
   input  logic              clear,
   input  logic              miss_inc,
   input  logic              miss_clr,
   output logic [SLOT_W-1:0] slot,
   output logic              miss_hit
);

   logic [2:0] miss_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         slot     <= '0;
         miss_cnt <= '0;
      end else begin
         if (clear)
            slot <= '0;
         else if (load_one)
            slot <= SLOT_W'(1);
         else if (inc)
            slot <= slot + SLOT_W'(1);

         if (miss_clr)
            miss_cnt <= '0;
         else if (miss_inc)
            miss_cnt <= miss_cnt + 3'd1;
      end
   end

   // Looks ahead: true when the miss being counted this cycle reaches the limit.
   assign miss_hit = (miss_cnt + 3'd1) == 3'(MISS_LIMIT);

endmodule

// File: rtl/tdm_demux_8ch.sv
// Receive end of the 8:1 TDM path: steers slot samples into capture registers
// and publishes each complete frame atomically.
//
//   state  | meaning
//   HUNT   | waiting for a frame_sync; unsynchronised samples dropped
//   LOCKED | tracking slots; early/missing sync flagged via sync_err
module tdm_demux_8ch
   import tdm_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int MISS_LIMIT = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DATA_W-1:0]           din,
   input  logic                        din_valid,
   input  logic                        frame_sync,
   output logic [NUM_SLOTS*DATA_W-1:0] frame_out,
   output logic                        frame_valid,
   output logic                        locked,
   output logic                        sync_err,
   output logic [SLOT_W-1:0]           slot
);

   localparam logic [0:0] ST_HUNT   = HUNT;
   localparam logic [0:0] ST_LOCKED = LOCKED;

   logic [0:0]              state, state_nx;
   logic [DATA_W-1:0]       cap [NUM_SLOTS];
   logic [NUM_SLOTS*DATA_W-1:0] frame_nx;
   logic                    wr_en, wr_zero, inc, load_one, clear;
   logic                    miss_inc, miss_clr, miss_hit, err_nx, done;

   tdm_slot_ctr #(.MISS_LIMIT(MISS_LIMIT)) u_slot_ctr (
      .clk      (clk),
      .rst      (rst),
      .inc      (inc),
      .load_one (load_one),
      .clear    (clear),
      .miss_inc (miss_inc),
      .miss_clr (miss_clr),
      .slot     (slot),
      .miss_hit (miss_hit)
   );

   always_comb begin
      state_nx = state;
      wr_en    = 1'b0;
      wr_zero  = 1'b0;
      inc      = 1'b0;
      load_one = 1'b0;
      clear    = 1'b0;
      miss_inc = 1'b0;
      miss_clr = 1'b0;
      err_nx   = 1'b0;
      done     = 1'b0;
      if (din_valid) begin
         case (state)
            ST_HUNT: begin
               if (frame_sync) begin
                  wr_en    = 1'b1;
                  wr_zero  = 1'b1;
                  load_one = 1'b1;
                  miss_clr = 1'b1;
                  state_nx = ST_LOCKED;
               end
            end
            default: begin
               if (frame_sync) begin
                  wr_en    = 1'b1;
                  wr_zero  = 1'b1;
                  load_one = 1'b1;
                  miss_clr = 1'b1;
                  err_nx   = (slot != '0);
               end else if (slot == '0) begin
                  err_nx   = 1'b1;
                  miss_inc = 1'b1;
                  if (miss_hit) begin
                     clear    = 1'b1;
                     state_nx = ST_HUNT;
                  end else begin
                     wr_en    = 1'b1;
                     wr_zero  = 1'b1;
                     load_one = 1'b1;
                  end
               end else begin
                  wr_en = 1'b1;
                  inc   = 1'b1;
                  done  = (slot == SLOT_W'(NUM_SLOTS - 1));
               end
            end
         endcase
      end
   end

   // Slot 7 goes straight from din into the output buffer, so the frame is
   // published on the same edge that accepts its last sample.
   always_comb begin
      frame_nx = '0;
      for (int k = 0; k < NUM_SLOTS - 1; k++)
         frame_nx[k*DATA_W +: DATA_W] = cap[k];
      frame_nx[(NUM_SLOTS-1)*DATA_W +: DATA_W] = din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_HUNT;
         frame_out   <= '0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
         for (int k = 0; k < NUM_SLOTS; k++)
            cap[k] <= '0;
      end else begin
         state       <= state_nx;
         frame_valid <= done;
         sync_err    <= err_nx;
         if (wr_en)
            cap[wr_zero ? '0 : slot] <= din;
         if (done)
            frame_out <= frame_nx;
      end
   end

   assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_tdm_demux_8ch.sv
// Scoreboard bench for tdm_demux_8ch: a 4-bit and a 1-bit instance share one
// control stream; a slot-level reference model predicts frames and sync errors.
module tb_tdm_demux_8ch;

   localparam int MISS_LIMIT = 2;

   typedef struct {
      int          t;
      logic [31:0] f;
   } fev_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  din4 = '0;
   logic        din1;
   logic        din_valid = 1'b0;
   logic        frame_sync = 1'b0;

   logic [31:0] fo4;
   logic [7:0]  fo1;
   logic        fv4, fv1, lk4, lk1, se4, se1;
   logic [2:0]  sl4, sl1;

   assign din1 = din4[0];

   tdm_demux_8ch #(.DATA_W(4), .MISS_LIMIT(MISS_LIMIT)) dut_w4 (
      .clk(clk), .rst(rst), .din(din4), .din_valid(din_valid),
      .frame_sync(frame_sync), .frame_out(fo4), .frame_valid(fv4),
      .locked(lk4), .sync_err(se4), .slot(sl4)
   );

   tdm_demux_8ch #(.DATA_W(1), .MISS_LIMIT(MISS_LIMIT)) dut_w1 (
      .clk(clk), .rst(rst), .din(din1), .din_valid(din_valid),
      .frame_sync(frame_sync), .frame_out(fo1), .frame_valid(fv1),
      .locked(lk1), .sync_err(se1), .slot(sl1)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   bit   armed = 1'b0;

   fev_t fq[$];
   int   eq[$];

   // reference model state, expressed as the values visible after the next edge
   bit          m_locked = 1'b0;
   int          m_slot   = 0;
   int          m_miss   = 0;
   logic [3:0]  m_buf [8];
   logic [31:0] m_fo     = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [7:0] bit0_of(input logic [31:0] f);
      logic [7:0] r;
      for (int k = 0; k < 8; k++)
         r[k] = f[4*k];
      return r;
   endfunction

   task automatic step(input bit r, input bit v, input bit fs, input logic [3:0] d);
      @(negedge clk);
      rst        = r;
      din_valid  = v;
      frame_sync = fs;
      din4       = d;
      if (r) begin
         m_locked = 1'b0;
         m_slot   = 0;
         m_miss   = 0;
         m_fo     = '0;
      end else if (v) begin
         if (!m_locked) begin
            if (fs) begin
               m_buf[0] = d;
               m_slot   = 1;
               m_miss   = 0;
               m_locked = 1'b1;
            end
         end else if (fs) begin
            if (m_slot != 0)
               eq.push_back(cyc + 1);
            m_buf[0] = d;
            m_slot   = 1;
            m_miss   = 0;
         end else if (m_slot == 0) begin
            eq.push_back(cyc + 1);
            m_miss++;
            if (m_miss == MISS_LIMIT) begin
               m_locked = 1'b0;
            end else begin
               m_buf[0] = d;
               m_slot   = 1;
            end
         end else begin
            m_buf[m_slot] = d;
            if (m_slot == 7) begin
               for (int k = 0; k < 8; k++)
                  m_fo[4*k +: 4] = m_buf[k];
               fq.push_back('{t: cyc + 1, f: m_fo});
               m_slot = 0;
            end else begin
               m_slot++;
            end
         end
      end
   endtask

   task automatic frame(input bit with_sync, input logic [3:0] vals [8]);
      for (int k = 0; k < 8; k++)
         step(1'b0, 1'b1, with_sync && (k == 0), vals[k]);
   endtask

   task automatic rand_frame(input bit with_sync);
      logic [3:0] v [8];
      for (int k = 0; k < 8; k++)
         v[k] = 4'($urandom_range(0, 15));
      frame(with_sync, v);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
   endtask

   // monitor: per-cycle state compare plus scoreboard pops on output pulses
   initial begin
      bit exp_fv, exp_se;
      fev_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (armed) begin
            chk("locked_w4", 32'(lk4), 32'(m_locked));
            chk("locked_w1", 32'(lk1), 32'(m_locked));
            chk("slot_w4", 32'(sl4), 32'(m_slot));
            chk("slot_w1", 32'(sl1), 32'(m_slot));
            chk("frame_out_w4", fo4, m_fo);
            chk("frame_out_w1", 32'(fo1), 32'(bit0_of(m_fo)));

            if (fq.size() != 0 && fq[0].t < cyc) begin
               chk("frame_valid_missed", 32'(fq[0].t), 32'(cyc));
               void'(fq.pop_front());
            end
            exp_fv = (fq.size() != 0) && (fq[0].t == cyc);
            chk("frame_valid_w4", 32'(fv4), 32'(exp_fv));
            chk("frame_valid_w1", 32'(fv1), 32'(exp_fv));
            if (exp_fv) begin
               e = fq.pop_front();
               chk("frame_data_w4", fo4, e.f);
               chk("frame_data_w1", 32'(fo1), 32'(bit0_of(e.f)));
            end

            if (eq.size() != 0 && eq[0] < cyc) begin
               chk("sync_err_missed", 32'(eq[0]), 32'(cyc));
               void'(eq.pop_front());
            end
            exp_se = (eq.size() != 0) && (eq[0] == cyc);
            chk("sync_err_w4", 32'(se4), 32'(exp_se));
            chk("sync_err_w1", 32'(se1), 32'(exp_se));
            if (exp_se)
               void'(eq.pop_front());
         end
      end
   end

   initial begin
      logic [3:0] pat [8];
      logic [3:0] cnt [8];
      bit r, v, fs;

      // reset and lock
      step(1'b1, 1'b0, 1'b0, 4'h0);
      armed = 1'b1;
      step(1'b1, 1'b0, 1'b0, 4'h0);
      pat = '{4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0};
      frame(1'b1, pat);
      idle(2);
      chk("lock_frame_const_w1", 32'(fo1), 32'h4D);

      // hunt discard
      step(1'b1, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 1'b0, 4'($urandom_range(0, 15)));
      rand_frame(1'b1);
      idle(1);

      // early sync at slot 5
      for (int k = 0; k < 5; k++)
         step(1'b0, 1'b1, k == 0, 4'($urandom_range(0, 15)));
      rand_frame(1'b1);
      idle(1);

      // missing sync: one omission flywheels, two consecutive drop lock
      rand_frame(1'b1);
      rand_frame(1'b0);
      rand_frame(1'b1);
      rand_frame(1'b0);
      rand_frame(1'b0);
      idle(2);

      // gapped valid
      cnt = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
      for (int k = 0; k < 8; k++) begin
         step(1'b0, 1'b1, k == 0, cnt[k]);
         if (k != 7)
            step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end
      idle(1);
      chk("gapped_frame_const_w4", fo4, 32'h7654_3210);

      // reset mid-frame at slot 4
      for (int k = 0; k < 4; k++)
         step(1'b0, 1'b1, k == 0, 4'($urandom_range(0, 15)));
      step(1'b1, 1'b0, 1'b0, 4'h0);
      idle(2);

      // random soak
      for (int i = 0; i < 600; i++) begin
         r = ($urandom_range(0, 149) == 0);
         v = ($urandom_range(0, 9) < 8);
         if (!m_locked)
            fs = ($urandom_range(0, 3) == 0);
         else if (m_slot == 0)
            fs = ($urandom_range(0, 9) < 8);
         else
            fs = ($urandom_range(0, 39) == 0);
         step(r, v, fs, 4'($urandom_range(0, 15)));
      end
      idle(3);
      @(negedge clk);

      chk("frames_left_in_queue", 32'(fq.size()), 32'd0);
      chk("sync_errs_left_in_queue", 32'(eq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tdm_demux_8ch.md
Name: tdm_demux_8ch

Overview:
Time-division demultiplexer, the receive end of the team's 8:1 select-line mux path. Accepts one sample per valid cycle from a serial slot stream with a frame-sync marker on slot 0. Steers each sample into one of 8 channel registers. Publishes the complete 8-channel frame atomically, tracking frame lock and sync errors.

Parameters:
DATA_W, 1, width of one slot sample in bits
MISS_LIMIT, 2, consecutive frames with missing sync before lock is dropped (range 1..7)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
din  input  DATA_W  slot sample
din_valid  input  1  din (and frame_sync) qualified this cycle
frame_sync  input  1  marks the current valid sample as slot 0; ignored when din_valid=0
frame_out  output  8*DATA_W  last complete frame; slot k at bits [k*DATA_W +: DATA_W]
frame_valid  output  1  one-cycle pulse, frame_out updated this cycle
locked  output  1  high while in LOCKED state
sync_err  output  1  one-cycle pulse on unexpected or missing sync
slot  output  3  index of the next slot to be written (0..7)

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). Reset is the only reset.
- Reset values: state=HUNT, slot=0, miss_cnt=0, capture regs=0, frame_out=0, frame_valid=0, locked=0, sync_err=0.
- rst mid-frame: partial frame discarded. frame_out cleared to 0. No frame_valid.
- din_valid=0: all state holds. frame_valid and sync_err deassert.
- Slot counter is 3-bit and wraps 7->0 naturally.
- Slot k sample corresponds to mux input k (select value k).
- State HUNT:
  - Valid samples without frame_sync are discarded.
  - Valid sample with frame_sync: write capture[0], slot<=1, miss_cnt<=0, go LOCKED.
  - locked=1 from the next cycle.
- State LOCKED, on each valid sample:
  - frame_sync=1, slot=0: normal. Write capture[0], slot<=1, miss_cnt<=0.
  - frame_sync=1, slot!=0: early sync. Pulse sync_err. Partial frame discarded, no frame_valid. Write capture[0], slot<=1, miss_cnt<=0. Stay LOCKED.
  - frame_sync=0, slot=0: missing sync. Pulse sync_err, miss_cnt+1.
    - If the new miss_cnt equals MISS_LIMIT: go HUNT, slot<=0, sample discarded, locked=0 from the next cycle.
    - Otherwise: accept the sample as slot 0 (flywheel).
  - frame_sync=0, slot!=0: write capture[slot], slot<=slot+1.
- Frame completion:
  - The cycle a slot-7 sample is accepted, the next edge loads frame_out from capture[0..6] plus din.
  - frame_valid=1 for exactly that following cycle. Latency is 1 clk from the slot-7 sample to frame_valid.
  - frame_out holds until the next completion or rst.
- Back-to-back: with din_valid=1 continuously, frame_valid pulses every 8 cycles.
- A slot-0 write in the same cycle as frame_valid does not disturb frame_out (double-buffered).
- sync_err and frame_valid never pulse for the same sample.

Decomposition:
- Package tdm_pkg holds:
  - NUM_SLOTS=8
  - SLOT_W=3
  - state enum {HUNT, LOCKED}
  - slot-field helper constant DATA_W default
- One sub-module, tdm_slot_ctr: 3-bit slot counter with load-to-1, clear, and increment-on-valid, plus the miss_cnt compare.
- Capture registers, output buffer and FSM stay in the top.

Test Plan:
- Reset and lock (DATA_W=1): rst 2 cycles, then stream sync+1,0,1,1,0,0,1,0 continuously.
  - Required: locked=1 after the first sample; frame_valid one cycle after the 8th sample; frame_out=8'b0100_1101.
- Hunt discard: 3 valid samples without sync before the first sync.
  - Required: samples ignored, locked=0 throughout, slot=0; the first frame captured correctly after sync.
- Early sync: locked, frame_sync at slot 5.
  - Required: sync_err pulse, no frame_valid, slot=1 next cycle; the following 8-sample frame is output intact.
- Missing sync with MISS_LIMIT=2: omit sync on 1 frame.
  - Required: one sync_err, frame still output, locked stays 1.
  - Omit on 2 consecutive frames: second sync_err, locked=0, slot=0, no second frame_valid.
- Gapped valid (DATA_W=4): din_valid toggles 1,0,1,0 through a frame of samples 0x0..0x7.
  - Required: frame_out=32'h7654_3210; frame_valid one cycle after the last valid.
- Reset mid-frame: rst asserted at slot 4.
  - Required: frame_out=0, locked=0, slot=0 next cycle, no frame_valid.
